// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Bit-period counter width: one spare bit above what CLKS_PER_BIT-1 needs.
  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit) + 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchroniser for the asynchronous RX line; all stages reset to the idle level.
`timescale 1ns/1ps
module uart_sync
  import uart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= {STAGES{LINE_IDLE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a one-entry ready/valid output buffer.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) between data and stop.
`timescale 1ns/1ps
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
  localparam logic        PAR_SENSE  = (PARITY_ODD != 0);
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || SYNC_STAGES < 2 ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_rx_param: illegal parameter set");
  end

  logic rxs;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (CLK),
    .srst_i(RESET),
    .d_i   (RX),
    .q_o   (rxs)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 word_done, frame_bad, par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Frame sequencer: every sample point is reached when the bit counter hits zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    frame_bad = 1'b0;
    par_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (rxs != LINE_IDLE) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rxs != LINE_IDLE) begin
            state_d = DATA;
            idx_d   = '0;
            cnt_d   = CNT_FULL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = AFTER_DATA;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          par_bit_d = rxs;
          cnt_d     = CNT_FULL;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
`ifdef UART_RX_PARITY_EN
          par_bad = ((^shreg_q) ^ PAR_SENSE) != par_bit_q;
`endif
          // A parity failure owns the frame: the stop bit only steers WAIT_HIGH entry.
          if (rxs == LINE_IDLE) begin
            state_d   = IDLE;
            word_done = !par_bad;
          end else begin
            state_d   = WAIT_HIGH;
            frame_bad = !par_bad;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs == LINE_IDLE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = frame_bad;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = par_bad;
`endif
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (word_done) begin
      if (!valid_q || ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: frame table, hand-written corner sequences, random frames vs a queue model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int SS   = 2;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int   P      = 1;
  localparam logic PODD_B = (PODD != 0);
`else
  localparam int P = 0;
`endif
  localparam int LAT = SS + CPB / 2 + (DB + P + 1) * CPB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          ready = 1'b0;
  logic [DB-1:0] data;
  logic          valid, frame_err, overrun, parity_err;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .SYNC_STAGES (SS),
    .PARITY_ODD  (PODD)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .RX        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [DB-1:0] got_q[$];
  int   ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, rise_cnt = 0;
  int   rise_cyc = -1, ovr_cyc = -1;
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (valid && !valid_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    valid_prev <= valid;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return 32'(got_q[i]);
    return 'x;
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; c0 is the edge count when the start bit begins.
  task automatic send_frame(input logic [DB-1:0] w, input logic stop_b, input logic par_flip,
                            output int c0);
    c0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(w[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^w) ^ PODD_B ^ par_flip);
`endif
    drive_bit(stop_b);
    $display("frame word=0x%02h stop=%0b par_flip=%0b start_cycle=%0d", w, stop_b, par_flip, c0);
  endtask

  typedef struct {
    logic [DB-1:0] word;
    logic          stop_b;
    int            exp_words;
    int            exp_ferr;
  } vec_t;

  vec_t          vecs[6];
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] rw;
  logic          rsb;
  int            c0, c1, g0, f0, o0, p0, r0, gap, exp_ferr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h5A, 1'b0, 0, 1};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b0, 0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Single frame, ready high: one valid pulse at the computed latency
    ready = 1'b1;
    g0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt; r0 = rise_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, c0);
    drive_bit(1'b1);
    check("t1_words", 32'(got_q.size() - g0), 32'd1);
    check("t1_data", got_at(g0), 32'hA5);
    check("t1_rises", 32'(rise_cnt - r0), 32'd1);
    check("t1_latency", 32'(rise_cyc - c0), 32'(LAT));
    check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t1_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("t1_perr", 32'(perr_cnt - p0), 32'd0);

    // Back-to-back frames while the buffer is held: second word dropped
    ready = 1'b0;
    g0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, c0);
    send_frame(8'hC3, 1'b1, 1'b0, c1);
    drive_bit(1'b1);
    check("t2_ovr_count", 32'(ovr_cnt - o0), 32'd1);
    check("t2_ovr_cycle", 32'(ovr_cyc - c1), 32'(LAT));
    check("t2_valid_held", 32'(valid), 32'd1);
    check("t2_data_held", 32'(data), 32'h3C);
    check("t2_no_accept", 32'(got_q.size() - g0), 32'd0);
    check("t2_ferr", 32'(ferr_cnt - f0), 32'd0);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("t2_valid_drop", 32'(valid), 32'd0);
    check("t2_accept_count", 32'(got_q.size() - g0), 32'd1);
    check("t2_accept_data", got_at(g0), 32'h3C);
    repeat (4) @(posedge clk);
    #1;
    check("t2_valid_stays_low", 32'(valid), 32'd0);

    // Short low glitch is rejected as a false start
    ready = 1'b1;
    g0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt; r0 = rise_cnt;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("t3_glitch_rises", 32'(rise_cnt - r0), 32'd0);
    check("t3_glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t3_glitch_ovr", 32'(ovr_cnt - o0), 32'd0);
    send_frame(8'h55, 1'b1, 1'b0, c0);
    drive_bit(1'b1);
    check("t3_words", 32'(got_q.size() - g0), 32'd1);
    check("t3_data", got_at(g0), 32'h55);

    // Bad stop bit followed by a long break: exactly one frame_err
    g0 = got_q.size(); f0 = ferr_cnt; r0 = rise_cnt;
    send_frame(8'hE7, 1'b0, 1'b0, c0);
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("t4_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    check("t4_no_valid", 32'(rise_cnt - r0), 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0, c0);
    drive_bit(1'b1);
    check("t4_words", 32'(got_q.size() - g0), 32'd1);
    check("t4_data", got_at(g0), 32'h0F);
    check("t4_ferr_total", 32'(ferr_cnt - f0), 32'd1);

    // Frame table
    for (int v = 0; v < 6; v++) begin
      g0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[v].word, vecs[v].stop_b, 1'b0, c0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check($sformatf("vec%0d_words", v), 32'(got_q.size() - g0), 32'(vecs[v].exp_words));
      if (vecs[v].exp_words == 1)
        check($sformatf("vec%0d_data", v), got_at(g0), 32'(vecs[v].word));
      check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - o0), 32'd0);
    end

`ifdef UART_RX_PARITY_EN
    // Parity: matching bit accepted, flipped bit rejected with parity_err only
    g0 = got_q.size(); f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0, c0);
    drive_bit(1'b1);
    check("par_ok_words", 32'(got_q.size() - g0), 32'd1);
    check("par_ok_data", got_at(g0), 32'h07);
    check("par_ok_perr", 32'(perr_cnt - p0), 32'd0);
    g0 = got_q.size(); r0 = rise_cnt;
    send_frame(8'h07, 1'b1, 1'b1, c0);
    drive_bit(1'b1);
    check("par_bad_perr", 32'(perr_cnt - p0), 32'd1);
    check("par_bad_no_valid", 32'(rise_cnt - r0), 32'd0);
    check("par_bad_ferr", 32'(ferr_cnt - f0), 32'd0);
`endif

    // Random frames against a queue model: good stop bits deliver the word, bad ones count an error
    exp_q.delete();
    exp_ferr = 0;
    g0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    for (int k = 0; k < 10; k++) begin
      rw  = DB'($urandom);
      rsb = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 2);
      if (!rsb && gap == 0) gap = 1;
      send_frame(rw, rsb, 1'b0, c0);
      if (rsb) exp_q.push_back(rw);
      else exp_ferr++;
      for (int j = 0; j < gap; j++) drive_bit(1'b1);
    end
    drive_bit(1'b1);
    check("rand_words", 32'(got_q.size() - g0), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("rand_data%0d", k), got_at(g0 + k), 32'(exp_q[k]));
    check("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
    check("rand_ovr", 32'(ovr_cnt - o0), 32'd0);

    // Reset mid-DATA while a word is buffered
    ready = 1'b0;
    g0 = got_q.size(); f0 = ferr_cnt;
    send_frame(8'h22, 1'b1, 1'b0, c0);
    drive_bit(1'b1);
    check("t6_valid_before", 32'(valid), 32'd1);
    check("t6_data_before", 32'(data), 32'h22);
    rw = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rw[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid_after_rst", 32'(valid), 32'd0);
    check("t6_data_after_rst", 32'(data), 32'd0);
    rst = 1'b0;
    rx  = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    ready = 1'b1;
    send_frame(8'h18, 1'b1, 1'b0, c0);
    drive_bit(1'b1);
    check("t6_words", 32'(got_q.size() - g0), 32'd1);
    check("t6_data", got_at(g0), 32'h18);
    check("t6_ferr", 32'(ferr_cnt - f0), 32'd0);

`ifndef UART_RX_PARITY_EN
    check("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
